// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the two writeback requesters, the arbiter, and the register-file write port.
// Requesters drive through the master modport; the arbiter owns the slave modport.
interface regfile_write_arbiter_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  freeze;
   logic                  req0_valid;
   logic                  req0_lock;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_data;
   logic                  req0_ready;
   logic                  req1_valid;
   logic                  req1_lock;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_data;
   logic                  req1_ready;
   logic                  wr_enable;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  last_grant;
   logic [7:0]            drop_count;

   modport master (
      output freeze,
      output req0_valid, req0_lock, req0_addr, req0_data,
      output req1_valid, req1_lock, req1_addr, req1_data,
      input  req0_ready, req1_ready,
      input  wr_enable, wr_addr, wr_data, last_grant, drop_count
   );

   modport slave (
      input  freeze,
      input  req0_valid, req0_lock, req0_addr, req0_data,
      input  req1_valid, req1_lock, req1_addr, req1_data,
      output req0_ready, req1_ready,
      output wr_enable, wr_addr, wr_data, last_grant, drop_count
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter with locked bursts for the register-file write port; 1-cycle latency to wr_*.
// Backpressure: ready is a combinational grant, withheld while frozen, in reset, or locked to the other side.
module regfile_write_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   regfile_write_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  wr_enable_q, wr_enable_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [7:0]            drop_count_q, drop_count_d;

   logic                  gnt0, gnt1, xfer, sel_lock;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset_n && !bus.freeze) begin
         case (state_q)
            IDLE: begin
               if (bus.req0_valid && bus.req1_valid) begin
                  // Tie goes to whoever did not win last time.
                  gnt0 = last_grant_q;
                  gnt1 = !last_grant_q;
               end else begin
                  gnt0 = bus.req0_valid;
                  gnt1 = bus.req1_valid;
               end
            end
            LOCK0:   gnt0 = bus.req0_valid;
            LOCK1:   gnt1 = bus.req1_valid;
            default: ;
         endcase
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;

   always_comb begin
      xfer         = gnt0 | gnt1;
      sel_lock     = gnt1 ? bus.req1_lock : bus.req0_lock;
      sel_addr     = gnt1 ? bus.req1_addr : bus.req0_addr;
      sel_data     = gnt1 ? bus.req1_data : bus.req0_data;
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wr_enable_d  = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      drop_count_d = drop_count_q;
      if (xfer) begin
         last_grant_d = gnt1;
         if (sel_lock) begin
            state_d = gnt1 ? LOCK1 : LOCK0;
         end else begin
            state_d = IDLE;
         end
         if (sel_addr != '0) begin
            wr_enable_d = 1'b1;
            wr_addr_d   = sel_addr;
            wr_data_d   = sel_data;
         end else if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         wr_enable_q  <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         drop_count_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wr_enable_q  <= wr_enable_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign bus.wr_enable  = wr_enable_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.last_grant = last_grant_q;
   assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_regfile_write_arbiter;
   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   regfile_write_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

   regfile_write_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit expired, act=running req=finished");
      $fatal(1, "watchdog");
   end

   // Model: burst owner (-1 = none), last winner, and the write port contents it should show.
   int          m_owner;
   int          m_last;
   bit          m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   int          m_drop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = 1;
      m_we    = 1'b0;
      m_wa    = '0;
      m_wd    = '0;
      m_drop  = 0;
   endtask

   function automatic int model_winner();
      bit v0, v1;
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      if (!reset_n || bus.freeze) return -1;
      if (m_owner == 0) return v0 ? 0 : -1;
      if (m_owner == 1) return v1 ? 1 : -1;
      if (v0 && v1) return 1 - m_last;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   // One clock: compare everything at the negedge, advance the model, land at posedge+1 for new stimulus.
   task automatic step();
      int          w;
      logic [4:0]  a;
      logic [31:0] d;
      bit          lk;
      @(negedge clk);
      w = model_winner();
      chk("req0_ready", 32'(bus.req0_ready), 32'(w == 0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(w == 1));
      chk("wr_enable", 32'(bus.wr_enable), 32'(m_we));
      chk("wr_addr", 32'(bus.wr_addr), 32'(m_wa));
      chk("wr_data", bus.wr_data, m_wd);
      chk("last_grant", 32'(bus.last_grant), 32'(m_last));
      chk("drop_count", 32'(bus.drop_count), 32'(m_drop));
      m_we = 1'b0;
      if (w >= 0) begin
         a  = (w == 1) ? bus.req1_addr : bus.req0_addr;
         d  = (w == 1) ? bus.req1_data : bus.req0_data;
         lk = (w == 1) ? bus.req1_lock : bus.req0_lock;
         m_last  = w;
         m_owner = lk ? w : -1;
         if (a != 0) begin
            m_we = 1'b1;
            m_wa = a;
            m_wd = d;
         end else if (m_drop < 255) begin
            m_drop++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v0, input bit l0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit v1, input bit l1, input logic [4:0] a1, input logic [31:0] d1);
      bus.req0_valid = v0; bus.req0_lock = l0; bus.req0_addr = a0; bus.req0_data = d0;
      bus.req1_valid = v1; bus.req1_lock = l1; bus.req1_addr = a1; bus.req1_data = d1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      model_reset();
      reset_n    = 1'b0;
      bus.freeze = 1'b0;
      drive(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);

      // Reset state, including ready held low while both requesters are valid.
      drive(1, 0, 5'd3, 32'h1111, 1, 0, 5'd4, 32'h2222);
      step();
      step();
      drive(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
      reset_n = 1'b1;
      step();

      // Tie after reset: req0 first, then req1.
      drive(1, 0, 5'd3, 32'hAAAA0001, 1, 0, 5'd4, 32'hBBBB0002);
      step();
      chk("tie_wr_addr_1", 32'(bus.wr_addr), 32'd3);
      chk("tie_last_grant_1", 32'(bus.last_grant), 32'd0);
      step();
      chk("tie_wr_data_2", bus.wr_data, 32'hBBBB0002);
      chk("tie_last_grant_2", 32'(bus.last_grant), 32'd1);
      drive(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
      step();

      // Make req0 the last winner so req1 wins the next tie and opens its burst.
      drive(1, 0, 5'd8, 32'h8888, 0, 0, 5'd0, 32'd0);
      step();
      drive(1, 0, 5'd9, 32'h9999, 1, 1, 5'd5, 32'h5005);
      step();
      drive(1, 0, 5'd9, 32'h9999, 1, 1, 5'd6, 32'h6006);
      step();
      drive(1, 0, 5'd9, 32'h9999, 1, 0, 5'd7, 32'h7007);
      step();
      chk("burst_wr_addr", 32'(bus.wr_addr), 32'd7);
      drive(1, 0, 5'd9, 32'h9999, 0, 0, 5'd0, 32'd0);
      step();
      chk("burst_then_req0", 32'(bus.wr_addr), 32'd9);

      // Lock with a two-cycle gap while req0 waits.
      drive(1, 0, 5'd10, 32'hA0A0, 1, 1, 5'd11, 32'hB0B0);
      step();
      drive(1, 0, 5'd10, 32'hA0A0, 0, 0, 5'd0, 32'd0);
      step();
      step();
      chk("gap_no_write", 32'(bus.wr_enable), 32'd0);
      drive(1, 0, 5'd10, 32'hA0A0, 1, 0, 5'd12, 32'hC0C0);
      step();
      chk("gap_resume_addr", 32'(bus.wr_addr), 32'd12);
      drive(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
      step();

      // Register-0 writes saturate the drop counter.
      drive(1, 0, 5'd0, 32'hDEAD, 0, 0, 5'd0, 32'd0);
      for (int i = 0; i < 300; i++) step();
      chk("drop_saturated", 32'(bus.drop_count), 32'd255);
      drive(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
      step();

      // Freeze for three cycles with a tie pending; req1 wins on release.
      drive(1, 0, 5'd13, 32'hD0D0, 1, 0, 5'd14, 32'hE0E0);
      bus.freeze = 1'b1;
      for (int i = 0; i < 3; i++) step();
      bus.freeze = 1'b0;
      step();
      chk("freeze_release_winner", 32'(bus.last_grant), 32'd1);
      drive(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
      step();

      // Async reset in the middle of a req0 burst with a write in flight.
      drive(1, 1, 5'd15, 32'hF0F0, 0, 0, 5'd0, 32'd0);
      step();
      reset_n = 1'b0;
      #2;
      chk("rst_wr_enable", 32'(bus.wr_enable), 32'd0);
      chk("rst_drop_count", 32'(bus.drop_count), 32'd0);
      chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
      model_reset();
      #1;
      reset_n = 1'b1;
      drive(1, 0, 5'd16, 32'h1616, 1, 0, 5'd17, 32'h1717);
      step();
      chk("post_rst_winner", 32'(bus.last_grant), 32'd0);

      // Random traffic with occasional freeze and frequent register-0 hits.
      for (int i = 0; i < 2000; i++) begin
         bus.freeze     = ($urandom_range(0, 9) == 0);
         bus.req0_valid = ($urandom_range(0, 3) != 0);
         bus.req0_lock  = ($urandom_range(0, 2) == 0);
         bus.req0_addr  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         bus.req0_data  = $urandom;
         bus.req1_valid = ($urandom_range(0, 3) != 0);
         bus.req1_lock  = ($urandom_range(0, 2) == 0);
         bus.req1_addr  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         bus.req1_data  = $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
